// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_mask,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_mask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, DONE} state_t;

    localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_mask_q, mem_mask_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;
    logic          grant_d;
    logic          resp;
    logic          is_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_d_q: 1 when the most recent grant went to the data side
    logic          last_d_q, last_d_d;
    assign grant_d = d_req & (~i_req | ~last_d_q);
`else
    assign grant_d = d_req;
`endif

    // A response in the issue cycle itself cannot belong to this access
    assign resp = mem_valid & ~mem_req_q;
    assign is_d = (state_q == WAIT_D);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_mask_d  = mem_mask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_mask_d  = d_mask;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    state_d     = WAIT_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b1;
`endif
                end else if (i_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_mask_d  = 4'b0000;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    state_d     = WAIT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b0;
`endif
                end
            end
            WAIT_I, WAIT_D: begin
                if (resp) begin
                    if (is_d) begin
                        d_rdata_d = mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_done_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    if (is_d) begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_done_d  = 1'b1;
                    end
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_mask_q  <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_mask_q  <= mem_mask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_mask  = mem_mask_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign i_stall   = i_req & ~i_done_q;
    assign d_stall   = d_req & ~d_done_q;

endmodule
